// File: rtl/rhd_pkg.sv
// rhd_pkg: shared constants, read-FSM encoding and frame-length helper for the RHD frame packer
package rhd_pkg;
   localparam int          NUM_CH_DEF = 32;
   localparam logic [7:0]  SYNC0_DEF  = 8'hA5;
   localparam logic [7:0]  SYNC1_DEF  = 8'h5A;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC0,
      ST_SYNC1,
      ST_CNT,
      ST_HI,
      ST_LO,
      ST_CHK
   } rhd_state_e;
   function automatic int frame_len(input int n);
      return 2 * n + 4;
   endfunction
endpackage

// File: rtl/rhd_pingpong_buf.sv
// rhd_pingpong_buf: two-bank sample RAM with registered read port and per-bank full flags
module rhd_pingpong_buf import rhd_pkg::*; #(
   parameter  int NUM_CH = NUM_CH_DEF,
   localparam int IW     = $clog2(NUM_CH)
) (
   input  logic          sysclk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          wr_bank,
   input  logic [IW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic          set_full,
   input  logic          clr_full,
   input  logic          rd_en,
   input  logic          rd_bank,
   input  logic [IW-1:0] rd_addr,
   output logic [15:0]   rd_data,
   output logic [1:0]    full
);
   logic [15:0] mem [2][NUM_CH];
   // RAM write and one-cycle registered read
   always_ff @(posedge sysclk) begin
      if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_bank][rd_addr];
   end
   // full flags: fill marks the write bank, free clears the read bank; both may happen together
   always_ff @(posedge sysclk) begin
      if (rst) begin
         full <= '0;
      end else begin
         if (set_full) full[wr_bank] <= 1'b1;
         if (clr_full) full[rd_bank] <= 1'b0;
      end
   end
endmodule

// File: rtl/rhd_frame_packer.sv
// rhd_frame_packer: groups RHD sweeps into ping-pong banks and streams them as checksummed byte frames
module rhd_frame_packer import rhd_pkg::*; #(
   parameter int         NUM_CH = NUM_CH_DEF,
   parameter logic [7:0] SYNC0  = SYNC0_DEF,
   parameter logic [7:0] SYNC1  = SYNC1_DEF
) (
   input  logic        sysclk,
   input  logic        rst,
   input  logic [15:0] rhd_data,
   input  logic        rhd_data_en,
   input  logic        sweep_start,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  frame_cnt,
   output logic        overflow,
   output logic        busy
);
   localparam int IW = $clog2(NUM_CH);
   rhd_state_e    state, state_nx;
   logic [IW-1:0] ch_idx, eff_idx, w_idx, rd_addr;
   logic          wr_bank, rd_bank, wr_ok, last_ch, last_w, acc, rd_en;
   logic [1:0]    full;
   logic [15:0]   rd_q;
   logic [7:0]    chk;
   assign eff_idx  = sweep_start ? '0 : ch_idx;
   assign last_ch  = eff_idx == IW'(NUM_CH - 1);
   assign wr_ok    = rhd_data_en && !full[wr_bank];
   assign last_w   = w_idx == IW'(NUM_CH - 1);
   assign tx_valid = state != ST_IDLE;
   assign busy     = state != ST_IDLE;
   assign acc      = tx_valid && tx_ready;
   assign rd_en    = acc && (state == ST_CNT || (state == ST_LO && !last_w));
   assign rd_addr  = state == ST_CNT ? '0 : w_idx + 1'b1;
   rhd_pingpong_buf #(.NUM_CH(NUM_CH)) u_buf (
      .sysclk   (sysclk),
      .rst      (rst),
      .wr_en    (wr_ok),
      .wr_bank  (wr_bank),
      .wr_addr  (eff_idx),
      .wr_data  (rhd_data),
      .set_full (wr_ok && last_ch),
      .clr_full (acc && state == ST_CHK),
      .rd_en    (rd_en),
      .rd_bank  (rd_bank),
      .rd_addr  (rd_addr),
      .rd_data  (rd_q),
      .full     (full)
   );
   // write side: channel counter, bank toggle on a completed sweep, sticky drop flag
   always_ff @(posedge sysclk) begin
      if (rst) begin
         ch_idx   <= '0;
         wr_bank  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if ((sweep_start && ch_idx != '0) || (rhd_data_en && full[wr_bank])) overflow <= 1'b1;
         if (rhd_data_en) begin
            ch_idx <= last_ch ? '0 : eff_idx + 1'b1;
            if (wr_ok && last_ch) wr_bank <= ~wr_bank;
         end else if (sweep_start) begin
            ch_idx <= '0;
         end
      end
   end
   // read FSM next state and the byte presented for each state
   always_comb begin
      state_nx = state;
      tx_data  = 8'h00;
      case (state)
         ST_IDLE:  state_nx = full[rd_bank] ? ST_SYNC0 : ST_IDLE;
         ST_SYNC0: begin
            tx_data = SYNC0;
            if (acc) state_nx = ST_SYNC1;
         end
         ST_SYNC1: begin
            tx_data = SYNC1;
            if (acc) state_nx = ST_CNT;
         end
         ST_CNT: begin
            tx_data = frame_cnt;
            if (acc) state_nx = ST_HI;
         end
         ST_HI: begin
            tx_data = rd_q[15:8];
            if (acc) state_nx = ST_LO;
         end
         ST_LO: begin
            tx_data = rd_q[7:0];
            if (acc) state_nx = last_w ? ST_CHK : ST_HI;
         end
         ST_CHK: begin
            tx_data = chk;
            if (acc) state_nx = full[~rd_bank] ? ST_SYNC0 : ST_IDLE;
         end
         default:  state_nx = ST_IDLE;
      endcase
   end
   // read side registers: state, word index, checksum, bank and frame counters
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state     <= ST_IDLE;
         w_idx     <= '0;
         rd_bank   <= 1'b0;
         frame_cnt <= 8'h00;
         chk       <= 8'h00;
      end else begin
         state <= state_nx;
         if (acc) begin
            if (state == ST_CNT) begin
               chk   <= frame_cnt;
               w_idx <= '0;
            end
            if (state == ST_HI || state == ST_LO) chk <= chk ^ tx_data;
            if (state == ST_LO) w_idx <= w_idx + 1'b1;
            if (state == ST_CHK) begin
               rd_bank   <= ~rd_bank;
               frame_cnt <= frame_cnt + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_rhd_frame_packer.sv
// tb_rhd_frame_packer: scoreboard bench; stimulus pushes expected bytes, a monitor pops and compares
module tb_rhd_frame_packer;
   import rhd_pkg::*;
   localparam int N = 32;
   localparam int DRAIN_MAX = 20 * N + 400;
   logic        sysclk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] rhd_data = '0;
   logic        rhd_data_en = 1'b0;
   logic        sweep_start = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  frame_cnt;
   logic        overflow;
   logic        busy;
   logic [7:0]  exp_q [$];
   logic [15:0] w [N];
   logic [1:0]  rmode = 2'd0;
   logic        stalled = 1'b0;
   logic [7:0]  held = 8'h00;
   logic [7:0]  e;
   int          n_cmp = 0;
   int          n_bad = 0;

   rhd_frame_packer #(.NUM_CH(N)) dut (
      .sysclk      (sysclk),
      .rst         (rst),
      .rhd_data    (rhd_data),
      .rhd_data_en (rhd_data_en),
      .sweep_start (sweep_start),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .frame_cnt   (frame_cnt),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 sysclk = ~sysclk;

   function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s got %0h expected %0h", nm, act, expv);
      end
   endfunction

   // link ready: 0 = always ready, 1 = random, 2 = never ready
   always begin
      @(posedge sysclk);
      #1;
      tx_ready = (rmode == 2'd1) ? 1'($urandom_range(0, 1)) : (rmode == 2'd0);
   end

   // monitor: pops one expected byte per handshake and checks stall stability
   always @(negedge sysclk) begin
      if (!rst && tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte got %0h expected none", tx_data);
         end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {8'h00, tx_data}, {8'h00, e});
         end
      end
      if (stalled && !rst) begin
         chk("stall_valid", {15'h0, tx_valid}, 16'h1);
         chk("stall_data", {8'h00, tx_data}, {8'h00, held});
      end
      stalled = tx_valid && !tx_ready && !rst;
      held    = tx_data;
   end

   task automatic do_reset();
      @(posedge sysclk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge sysclk);
      #1;
      rst = 1'b0;
   endtask

   task automatic fill(input logic [15:0] base);
      for (int i = 0; i < N; i++) w[i] = base + 16'(i);
   endtask

   task automatic send(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sysclk);
         #1;
         rhd_data_en = 1'b1;
         rhd_data    = w[i];
         sweep_start = (i == 0);
      end
      @(posedge sysclk);
      #1;
      rhd_data_en = 1'b0;
      sweep_start = 1'b0;
   endtask

   task automatic push_frame(input logic [7:0] cnt);
      logic [7:0] x;
      x = cnt;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(cnt);
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(w[i][15:8]);
         exp_q.push_back(w[i][7:0]);
         x = x ^ w[i][15:8] ^ w[i][7:0];
      end
      exp_q.push_back(x);
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || tx_valid) && t < DRAIN_MAX) begin
         @(posedge sysclk);
         t++;
      end
      #1;
      n_cmp++;
      if (t >= DRAIN_MAX) begin
         n_bad++;
         $display("FAIL %s drain_timeout outstanding %0d expected 0", nm, exp_q.size());
      end
   endtask

   initial begin
      int t;
      // 1: reset state, then one frame with words 0x0100+i, hand-built expected bytes
      do_reset();
      chk("rst_tx_valid", {15'h0, tx_valid}, 16'h0);
      chk("rst_tx_data", {8'h00, tx_data}, 16'h0);
      chk("rst_busy", {15'h0, busy}, 16'h0);
      chk("rst_frame_cnt", {8'h00, frame_cnt}, 16'h0);
      chk("rst_overflow", {15'h0, overflow}, 16'h0);
      fill(16'h0100);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h00);
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(8'h01);
         exp_q.push_back(8'(i));
      end
      exp_q.push_back(8'h00);
      send(N);
      drain("s1");
      chk("s1_frame_cnt", {8'h00, frame_cnt}, 16'h1);
      chk("s1_overflow", {15'h0, overflow}, 16'h0);
      chk("s1_busy", {15'h0, busy}, 16'h0);
      // 2: random back-pressure, same byte stream
      do_reset();
      rmode = 2'd1;
      push_frame(8'h00);
      send(N);
      drain("s2");
      chk("s2_frame_cnt", {8'h00, frame_cnt}, 16'h1);
      // 3: three sweeps with link stalled; third sweep dropped
      rmode = 2'd2;
      do_reset();
      fill(16'h1000);
      push_frame(8'h00);
      send(N);
      fill(16'h2000);
      push_frame(8'h01);
      send(N);
      fill(16'h3000);
      send(N);
      repeat (4) @(posedge sysclk);
      #1;
      chk("s3_overflow", {15'h0, overflow}, 16'h1);
      chk("s3_valid_held", {15'h0, tx_valid}, 16'h1);
      chk("s3_sync0_held", {8'h00, tx_data}, 16'h00A5);
      chk("s3_busy", {15'h0, busy}, 16'h1);
      rmode = 2'd0;
      drain("s3");
      chk("s3_frame_cnt", {8'h00, frame_cnt}, 16'h2);
      // 4: sweep restarted after 10 words; only the new sweep is framed
      do_reset();
      fill(16'h4000);
      send(10);
      chk("s4_no_ovf_yet", {15'h0, overflow}, 16'h0);
      fill(16'h5000);
      push_frame(8'h00);
      send(N);
      drain("s4");
      chk("s4_overflow", {15'h0, overflow}, 16'h1);
      chk("s4_frame_cnt", {8'h00, frame_cnt}, 16'h1);
      // 5: 300 frames, counter byte wraps FF -> 00
      do_reset();
      for (int f = 0; f < 300; f++) begin
         fill(16'(f * 3));
         push_frame(8'(f));
         send(N);
         drain("s5");
      end
      chk("s5_frame_cnt", {8'h00, frame_cnt}, 16'd44);
      chk("s5_overflow", {15'h0, overflow}, 16'h0);
      // 6: reset while in HI, then a fresh frame
      fill(16'h6000);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h2C);
      send(N);
      t = 0;
      do begin
         @(posedge sysclk);
         t++;
      end while (exp_q.size() != 0 && t < 200);
      rmode = 2'd2;
      n_cmp++;
      if (t >= 200) begin
         n_bad++;
         $display("FAIL s6_header_timeout outstanding %0d expected 0", exp_q.size());
      end
      #1;
      chk("s6_in_hi_valid", {15'h0, tx_valid}, 16'h1);
      chk("s6_in_hi_data", {8'h00, tx_data}, 16'h0060);
      rst = 1'b1;
      @(posedge sysclk);
      #1;
      chk("s6_rst_valid", {15'h0, tx_valid}, 16'h0);
      chk("s6_rst_busy", {15'h0, busy}, 16'h0);
      chk("s6_rst_frame_cnt", {8'h00, frame_cnt}, 16'h0);
      rst = 1'b0;
      exp_q.delete();
      rmode = 2'd0;
      fill(16'h7000);
      push_frame(8'h00);
      send(N);
      drain("s6");
      chk("s6_frame_cnt", {8'h00, frame_cnt}, 16'h1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout reached expected finish");
      $fatal(1, "timeout");
   end
endmodule
